// File: rtl/fft_8_input_loader_pkg.sv
// fft_pkg: shared definitions for the FFT front end.
//   - default frame geometry (FFT_N_POINTS, FFT_DATA_W, FFT_LOG2N)
//   - cplx_t: one complex sample {re, im}
//   - loader_state_t: input loader state encoding
//   - bitrev(): reverse the low log2n bits of an index
package fft_pkg;

  localparam int unsigned FFT_N_POINTS = 8;
  localparam int unsigned FFT_DATA_W   = 16;
  localparam int unsigned FFT_LOG2N    = $clog2(FFT_N_POINTS);
  localparam int unsigned BITREV_MAX_W = 16;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    START,
    BUSY
  } loader_state_t;

  // Reverses bits [log2n-1:0] of v; bits above log2n come back as zero.
  // The loop bound is constant so the function stays synthesizable.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(
    input logic [BITREV_MAX_W-1:0] v,
    input int unsigned             log2n
  );
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < BITREV_MAX_W; b++) begin
      if (b < log2n) begin
        r[4'(log2n - 1 - b)] = v[4'(b)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_8_input_loader_frame_buf.sv
// fft_frame_buf: N-slot register array holding one component (real or imag)
// of a frame.
//   clk, rst   : clock, asynchronous active-high reset (clears all slots)
//   wr_en      : write wr_data into slot wr_slot this cycle
//   wr_slot    : physical slot index
//   wr_data    : sample component
//   clr_mask   : slots to zero this cycle (zero-padding of short frames)
//   slot_data  : registered slot contents
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = FFT_N_POINTS,
  parameter int unsigned DATA_W   = FFT_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(N_POINTS)-1:0]  wr_slot,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [N_POINTS-1:0]          clr_mask,
  output logic [DATA_W-1:0]            slot_data [N_POINTS]
);

  localparam int unsigned LOG2N = $clog2(N_POINTS);

  logic [DATA_W-1:0] data_q [N_POINTS];
  logic [DATA_W-1:0] data_d [N_POINTS];

  // The loader never clears the slot it writes in the same cycle, so the
  // write/clear priority below never actually resolves a conflict.
  always_comb begin
    data_d = data_q;
    for (int unsigned i = 0; i < N_POINTS; i++) begin
      if (wr_en && (wr_slot == LOG2N'(i))) begin
        data_d[i] = wr_data;
      end else if (clr_mask[i]) begin
        data_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_POINTS; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      data_q <= data_d;
    end
  end

  assign slot_data = data_q;

endmodule

// File: rtl/fft_8_input_loader.sv
// fft_8_input_loader: collects a serial complex sample stream into an
// N_POINTS frame, launches the FFT core with a one-cycle start pulse, then
// holds the frame and blocks input until the core reports done.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake (accept = valid && ready)
//   in_real/in_imag     : sample components
//   in_last             : ends a short frame; remaining slots are zeroed
//   fft_start           : one-cycle launch pulse to the core
//   fft_done            : core done level, looked at only while waiting
//   fft_real/fft_imag   : registered frame presented to the core
//   frame_cnt           : frames launched (wrapping)
//   pad_flag            : last launched frame was zero-padded
// Build option: FFT_LOADER_BITREV_EN stores sample n in slot bitrev(n) so the
// core receives the frame in bit-reversed order; otherwise slot = n.
module fft_8_input_loader
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = FFT_N_POINTS,
  parameter int unsigned DATA_W   = FFT_DATA_W,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              in_last,
  output logic              fft_start,
  input  logic              fft_done,
  output logic [DATA_W-1:0] fft_real [N_POINTS],
  output logic [DATA_W-1:0] fft_imag [N_POINTS],
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              pad_flag
);

  localparam int unsigned LOG2N = $clog2(N_POINTS);

  loader_state_t      state_q, state_d;
  logic [LOG2N-1:0]   wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               pad_q, pad_d;

  logic               accept;
  logic               wr_en;
  logic [LOG2N-1:0]   wr_slot;
  logic [N_POINTS-1:0] clr_mask;

  // Logical sample index -> physical slot.
  function automatic logic [LOG2N-1:0] slot_of(input logic [LOG2N-1:0] n);
`ifdef FFT_LOADER_BITREV_EN
    return LOG2N'(bitrev(BITREV_MAX_W'(n), LOG2N));
`else
    return n;
`endif
  endfunction

  assign in_ready  = (state_q == FILL);
  assign fft_start = (state_q == START);
  assign accept    = in_valid && in_ready;
  assign wr_slot   = slot_of(wr_idx_q);
  assign frame_cnt = frame_cnt_q;
  assign pad_flag  = pad_q;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    frame_cnt_d = frame_cnt_q;
    pad_d       = pad_q;
    wr_en       = 1'b0;
    clr_mask    = '0;

    unique case (state_q)
      IDLE: begin
        state_d = FILL;
      end

      FILL: begin
        if (accept) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + LOG2N'(1);
          if ((wr_idx_q == LOG2N'(N_POINTS - 1)) || in_last) begin
            state_d = START;
            pad_d   = in_last && (wr_idx_q != LOG2N'(N_POINTS - 1));
            // Padding is defined on logical indices; each one above the
            // last accepted index is mapped to its physical slot.
            if (pad_d) begin
              for (int unsigned k = 0; k < N_POINTS; k++) begin
                if (LOG2N'(k) > wr_idx_q) begin
                  clr_mask[slot_of(LOG2N'(k))] = 1'b1;
                end
              end
            end
          end
        end
      end

      START: begin
        wr_idx_d    = '0;
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        state_d     = BUSY;
      end

      BUSY: begin
        if (fft_done) begin
          state_d = FILL;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_idx_q    <= '0;
      frame_cnt_q <= '0;
      pad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      frame_cnt_q <= frame_cnt_d;
      pad_q       <= pad_d;
    end
  end

  fft_frame_buf #(
    .N_POINTS (N_POINTS),
    .DATA_W   (DATA_W)
  ) u_buf_real (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_slot   (wr_slot),
    .wr_data   (in_real),
    .clr_mask  (clr_mask),
    .slot_data (fft_real)
  );

  fft_frame_buf #(
    .N_POINTS (N_POINTS),
    .DATA_W   (DATA_W)
  ) u_buf_imag (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_slot   (wr_slot),
    .wr_data   (in_imag),
    .clr_mask  (clr_mask),
    .slot_data (fft_imag)
  );

endmodule

// File: tb/tb_fft_8_input_loader.sv
// Self-checking bench for fft_8_input_loader: a frame-level reference model
// advanced on each clock, compared against the DUT on every falling edge,
// plus hand-computed literal checks of the directed scenarios.
module tb_fft_8_input_loader;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int DW    = 16;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_ready, in_last, fft_start, fft_done, pad_flag;
  logic [DW-1:0] in_real, in_imag;
  logic [DW-1:0] fft_real [N];
  logic [DW-1:0] fft_imag [N];
  logic [CW-1:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fft_8_input_loader #(
    .N_POINTS (N),
    .DATA_W   (DW),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .in_last   (in_last),
    .fft_start (fft_start),
    .fft_done  (fft_done),
    .fft_real  (fft_real),
    .fft_imag  (fft_imag),
    .frame_cnt (frame_cnt),
    .pad_flag  (pad_flag)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] pack(input logic [DW-1:0] a [N]);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = a[i];
    return v;
  endfunction

  // Physical slot for logical sample n: binary digit reversal by arithmetic.
  function automatic int slot(input int n);
`ifdef FFT_LOADER_BITREV_EN
    int r;
    int v;
    r = 0;
    v = n;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
`else
    return n;
`endif
  endfunction

  // ---------------- reference model ----------------
  logic          m_ready = 1'b0, m_start = 1'b0, m_busy = 1'b0, m_fresh = 1'b1, m_pad = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  logic [DW-1:0] m_re [N];
  logic [DW-1:0] m_im [N];
  int            m_nacc = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready = 1'b0; m_start = 1'b0; m_busy = 1'b0; m_fresh = 1'b1;
      m_pad = 1'b0; m_cnt = '0; m_nacc = 0;
      for (int i = 0; i < N; i++) begin m_re[i] = '0; m_im[i] = '0; end
    end else if (m_fresh) begin
      m_fresh = 1'b0;
      m_ready = 1'b1;
    end else if (m_start) begin
      m_start = 1'b0;
      m_cnt   = m_cnt + 1'b1;
      m_busy  = 1'b1;
    end else if (m_busy) begin
      if (fft_done) begin m_busy = 1'b0; m_ready = 1'b1; end
    end else if (m_ready && in_valid) begin
      m_re[slot(m_nacc)] = in_real;
      m_im[slot(m_nacc)] = in_imag;
      m_nacc++;
      if (m_nacc == N || in_last) begin
        m_pad = (m_nacc < N);
        for (int k = m_nacc; k < N; k++) begin m_re[slot(k)] = '0; m_im[slot(k)] = '0; end
        m_nacc  = 0;
        m_ready = 1'b0;
        m_start = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  in_ready,  m_ready);
    chk("fft_start", fft_start, m_start);
    chk("frame_cnt", frame_cnt, m_cnt);
    chk("pad_flag",  pad_flag,  m_pad);
    chk("fft_real",  pack(fft_real), pack(m_re));
    chk("fft_imag",  pack(fft_imag), pack(m_im));
  end

  // ---------------- stimulus helpers (called just after a falling edge) ----------------
  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1; in_real = re; in_imag = im; in_last = last;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%0b expected=1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_real  = DW'($urandom);
    in_imag  = DW'($urandom);
    in_last  = 1'($urandom);
  endtask

  // From the START cycle: step into BUSY, pulse done, land in FILL.
  task automatic finish_core();
    @(negedge clk);
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: in_ready=%0b expected=1", in_ready);
    end
  endtask

  logic [127:0] exp_f1, exp_short;
  logic         lst;

  initial begin
`ifdef FFT_LOADER_BITREV_EN
    exp_f1    = 128'h0008_0004_0006_0002_0007_0003_0005_0001;
    exp_short = 128'h0000_0000_0000_0020_0000_0030_0000_0010;
`else
    exp_f1    = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    exp_short = 128'h0000_0000_0000_0000_0000_0030_0020_0010;
`endif
    in_valid = 1'b0; in_real = '0; in_imag = '0; in_last = 1'b0; fft_done = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_cnt",   frame_cnt, 8'd0);
    chk("rst_real",  pack(fft_real), 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_cycle1", in_ready, 1'b1);

    // Full frame 1..8, back to back
    for (int i = 1; i <= N; i++) send(DW'(i), '0, 1'b0);
    idle();
    chk("start_latency", fft_start, 1'b1);
    chk("frame1_real",   pack(fft_real), exp_f1);
    chk("model_frame1",  pack(m_re), exp_f1);
    @(negedge clk);
    chk("frame1_cnt", frame_cnt, 8'd1);

    // Core busy for 20 cycles
    repeat (20) @(negedge clk);
    chk("busy_ready", in_ready, 1'b0);
    chk("busy_hold",  pack(fft_real), exp_f1);
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    chk("done_ready", in_ready, 1'b1);

    // Short frame, then a full frame clears pad_flag
    send(16'h0010, '0, 1'b0);
    send(16'h0020, '0, 1'b0);
    send(16'h0030, '0, 1'b1);
    idle();
    chk("short_start", fft_start, 1'b1);
    chk("short_pad",   pad_flag, 1'b1);
    chk("short_real",  pack(fft_real), exp_short);
    chk("model_short", pack(m_re), exp_short);
    finish_core();
    for (int i = 0; i < N; i++) send(DW'($urandom), DW'($urandom), 1'b0);
    idle();
    chk("full_start", fft_start, 1'b1);
    chk("full_pad",   pad_flag, 1'b0);
    finish_core();

    // Gapped valid while loading 8 samples
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 1) == 1) begin idle(); @(negedge clk); end
      send(DW'($urandom), DW'($urandom), 1'b0);
    end
    idle();
    chk("gap_start", fft_start, 1'b1);
    finish_core();

    // Asynchronous reset mid-fill
    for (int i = 0; i < 5; i++) send(DW'($urandom), DW'($urandom), 1'b0);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", in_ready, 1'b0);
    chk("arst_start", fft_start, 1'b0);
    chk("arst_cnt",   frame_cnt, 8'd0);
    chk("arst_pad",   pad_flag, 1'b0);
    chk("arst_real",  pack(fft_real), 128'h0);
    chk("arst_imag",  pack(fft_imag), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) send(DW'($urandom), DW'($urandom), 1'b0);
    idle();
    @(negedge clk);
    chk("arst_cnt1", frame_cnt, 8'd1);

    // 256 frames with done held high: counter wraps to 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fft_done = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 256; f++) begin
      wait_ready();
      for (int j = 0; j < N; j++) begin
        lst = ($urandom_range(0, 15) == 0);
        send(DW'($urandom), DW'($urandom), lst);
        if (lst) break;
      end
      idle();
    end
    wait_ready();
    chk("wrap_cnt", frame_cnt, 8'd0);
    fft_done = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
